// File: rtl/div_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl_pkg
// Brief    : Shared op indices, FSM encoding and helpers for the divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_seq_ctrl_pkg;

    localparam int DIV_OP_DIV  = 0;
    localparam int DIV_OP_DIVU = 1;
    localparam int DIV_OP_MOD  = 2;
    localparam int DIV_OP_MODU = 3;

    localparam int DIV_ITERS  = 32;
    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set, otherwise pass through.
    function automatic logic [DIV_DATA_W-1:0] div_cneg(
        input logic [DIV_DATA_W-1:0] v,
        input logic                  neg
    );
        return neg ? (~v + DIV_DATA_W'(1)) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_core
// Brief    : One combinational radix-2 restoring shift-subtract step.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_sub;
    logic              w_ge;

    always_comb begin
        w_shift = {i_rem, i_quo[DATA_W-1]};
        w_ge    = (w_shift >= {1'b0, i_divisor});
        // When the subtraction is taken the true difference fits in DATA_W bits.
        w_sub   = w_shift[DATA_W-1:0] - i_divisor;
        o_rem   = w_ge ? w_sub : w_shift[DATA_W-1:0];
        o_quo   = {i_quo[DATA_W-2:0], w_ge};
    end

endmodule

`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl
// Brief    : Sequencer for a shared multi-cycle 32-bit divider (div/divu/mod/modu).
//            Optional macro DIV_EARLY_OUT_EN enables single-cycle trivial cases.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic              cancel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              mod_q, mod_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;

    logic              w_accept;
    logic              w_is_signed;
    logic              w_is_mod;
    logic              w_src1_neg;
    logic              w_src2_neg;
    logic [DATA_W-1:0] w_mag1;
    logic [DATA_W-1:0] w_mag2;
    logic [DATA_W-1:0] w_step_rem;
    logic [DATA_W-1:0] w_step_quo;
    logic [DATA_W-1:0] w_q_fix;
    logic [DATA_W-1:0] w_r_fix;

    assign w_is_signed = in_op[DIV_OP_DIV] | in_op[DIV_OP_MOD];
    assign w_is_mod    = in_op[DIV_OP_MOD] | in_op[DIV_OP_MODU];
    assign w_accept    = in_valid & ~cancel & (|in_op);
    assign w_src1_neg  = w_is_signed & in_src1[DATA_W-1];
    assign w_src2_neg  = w_is_signed & in_src2[DATA_W-1];
    assign w_mag1      = div_cneg(in_src1, w_src1_neg);
    assign w_mag2      = div_cneg(in_src2, w_src2_neg);

    div_iter_core #(
        .DATA_W    (DATA_W)
    ) u_iter (
        .i_rem     (rem_q),
        .i_quo     (quo_q),
        .i_divisor (dvsr_q),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    // Divide-by-zero keeps the all-ones quotient; the remainder fixup restores the dividend.
    assign w_q_fix = div_cneg(w_step_quo, qneg_q & ~dz_q);
    assign w_r_fix = div_cneg(w_step_rem, rneg_q);

`ifdef DIV_EARLY_OUT_EN
    logic              w_early;
    logic [DATA_W-1:0] w_early_res;

    always_comb begin
        w_early     = 1'b0;
        w_early_res = '0;
        if (w_mag2 == '0) begin
            w_early     = 1'b1;
            w_early_res = w_is_mod ? in_src1 : '1;
        end else if (w_mag1 < w_mag2) begin
            w_early     = 1'b1;
            w_early_res = w_is_mod ? in_src1 : '0;
        end else if (w_mag2 == DATA_W'(1)) begin
            w_early     = 1'b1;
            w_early_res = w_is_mod ? '0 : div_cneg(in_src1, w_src2_neg);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        res_d   = res_q;
        mod_d   = mod_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    mod_d   = w_is_mod;
                    qneg_d  = w_src1_neg ^ w_src2_neg;
                    rneg_d  = w_src1_neg;
                    dz_d    = (in_src2 == '0);
                    rem_d   = '0;
                    quo_d   = w_mag1;
                    dvsr_d  = w_mag2;
                    cnt_d   = '0;
                    state_d = ST_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (w_early) begin
                        res_d   = w_early_res;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_CALC: begin
                rem_d = w_step_rem;
                quo_d = w_step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                    res_d   = mod_q ? w_r_fix : w_q_fix;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cancel) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            res_q   <= '0;
            mod_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            res_q   <= res_d;
            mod_q   <= mod_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign out_result = res_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq_ctrl
// Brief    : Scoreboard bench for div_seq_ctrl with directed and random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    localparam logic [3:0] OP_DIV  = 4'b0001;
    localparam logic [3:0] OP_DIVU = 4'b0010;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_MODU = 4'b1000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        cancel = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_op = 4'b0;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] out_result;

    div_seq_ctrl #(
        .DATA_W     (32),
        .CNT_W      (6)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .cancel     (cancel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned t_valid;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   sink_mode = 0;   // 0: hold low, 1: random, 2: always high, 3: main drives

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic        sgn;
        logic        md;
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sbv;
        sgn = op[0] | op[2];
        md  = op[2] | op[3];
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            sa  = $signed(a);
            sbv = $signed(b);
            q   = sa / sbv;
            r   = sa % sbv;
        end else begin
            q = a / b;
            r = a % b;
        end
        return md ? r : q;
    endfunction

    function automatic int unsigned ref_lat(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        logic        sgn;
        logic [31:0] ma;
        logic [31:0] mb;
        sgn = op[0] | op[2];
        ma  = (sgn && a[31]) ? (32'd0 - a) : a;
        mb  = (sgn && b[31]) ? (32'd0 - b) : b;
        if (mb == 32'd0 || ma < mb || mb == 32'd1) return 1;
        return 33;
`else
        if (op == 4'b0) return 0;
        if (a === 'x || b === 'x) return 0;
        return 33;
`endif
    endfunction

    // Output sink: drives out_ready each cycle according to sink_mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0: out_ready = 1'b0;
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: out_ready = 1'b1;
                default: ;
            endcase
        end
    end

    // Monitor: samples on the falling edge and checks against the scoreboard.
    initial begin
        logic        pv;
        logic        pc;
        logic [31:0] pres;
        pv = 1'b0;
        pc = 1'b0;
        pres = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pv = 1'b0;
                pc = 1'b0;
            end else begin
                chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~in_ready});
                if (pc) chk("idle_after_release", {30'd0, out_valid, in_ready}, 32'd1);
                if (out_valid) begin
                    chk("ready_low_in_done", {31'd0, in_ready}, 32'd0);
                    if (!pv) begin
                        if (sb.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_valid: got result %h, expected no output", out_result);
                        end else begin
                            chk($sformatf("latency_op%0d", sb[0].id), cyc, sb[0].t_valid);
                        end
                    end else begin
                        chk("result_stable", out_result, pres);
                    end
                    if (cancel) begin
                        if (sb.size() > 0) void'(sb.pop_front());
                        pc = 1'b1;
                    end else if (out_ready) begin
                        if (sb.size() > 0) begin
                            chk($sformatf("result_op%0d", sb[0].id), out_result, sb[0].res);
                            void'(sb.pop_front());
                        end
                        pc = 1'b1;
                    end else begin
                        pc = 1'b0;
                    end
                end else begin
                    pc = cancel;
                end
                pv   = out_valid;
                pres = out_result;
            end
        end
    end

    int op_id = 0;

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) chk("timeout_in_ready", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        @(posedge clk);
        #1;
        wait_ready();
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        if (push) begin
            op_id++;
            sb.push_back('{res: ref_div(op, a, b), t_valid: cyc + ref_lat(op, a, b), id: op_id});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_src1  = $urandom;
        in_src2  = $urandom;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) chk("timeout_out_valid", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0 || !in_ready) chk("timeout_drain", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 20));
            2:       return 32'd0 - 32'($urandom_range(1, 20));
            3:       return 32'd0;
            4:       return 32'd1;
            5:       return (($urandom & 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",   {31'd0, in_ready},  32'd1);
        chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_busy",       {31'd0, busy},      32'd0);
        chk("rst_out_result", out_result,         32'd0);
        resetn = 1'b1;

        sink_mode = 1;
        issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(OP_MOD,  32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(OP_MODU, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(OP_DIV,  32'd5, 32'd0, 1'b1);
        issue(OP_MOD,  32'd5, 32'd0, 1'b1);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(OP_DIVU, 32'd3, 32'd10, 1'b1);
        issue(OP_MODU, 32'd0, 32'd0, 1'b1);
        drain();

        // Cancel in the tenth CALC cycle, then a fresh op.
        issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_in_ready", {31'd0, in_ready}, 32'd1);
        issue(OP_DIV, 32'd100, 32'd7, 1'b1);
        drain();

        // Cancel and invalid op in IDLE are both ignored.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        cancel   = 1'b1;
        in_op    = OP_DIV;
        in_src1  = 32'd50;
        in_src2  = 32'd5;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        in_op  = 4'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("idle_ignores_req", {31'd0, in_ready}, 32'd1);

        // Backpressure: hold the result for five cycles, then release.
        sink_mode = 0;
        issue(OP_DIVU, 32'd1000, 32'd9, 1'b1);
        wait_valid();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        sink_mode = 2;
        drain();

        // Cancel together with out_ready in DONE discards the result.
        sink_mode = 0;
        issue(OP_MODU, 32'd1000, 32'd9, 1'b1);
        wait_valid();
        sink_mode = 3;
        out_ready = 1'b1;
        cancel    = 1'b1;
        @(posedge clk);
        #1;
        cancel    = 1'b0;
        out_ready = 1'b0;
        chk("cancel_done_idle", {30'd0, out_valid, in_ready}, 32'd1);

        sink_mode = 1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            op = 4'b0001 << $urandom_range(0, 3);
            issue(op, pick(), pick(), 1'b1);
        end
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing controller for a multi-cycle 32-bit integer divider shared by the div.w, div.wu, mod.w and mod.wu ops in the EX stage.
- Accepts one op via valid/ready and runs a radix-2 restoring divider sub-module for 32 iterations.
- Applies sign and special-case fixups, then holds the result until EX consumes it.
- Supports pipeline cancel on exception or flush.

Parameters:
- DATA_W, 32, operand and result width. Only 32 is supported.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous reset, active-low.
- in_valid  in  1  EX presents a divide op.
- in_ready  out  1  controller can accept an op this cycle.
- in_op  in  4  one-hot op {modu, mod, divu, div}, bit0 = div, matching alu_op[18:15].
- in_src1  in  32  dividend (rj).
- in_src2  in  32  divisor (rk).
- cancel  in  1  flush; aborts any in-flight op.
- out_valid  out  1  result available.
- out_ready  in  1  EX consumes the result.
- out_result  out  32  quotient for div/divu, remainder for mod/modu.
- busy  out  1  high in CALC or DONE; used for the EX stall (ready_go = ~busy | out_valid).

Behaviour:
- Reset (resetn = 0 at a clock edge): state = IDLE, in_ready = 1, out_valid = 0, out_result = 0, busy = 0, counter = 0. Reset mid-operation discards the op.
- States:
  - IDLE: in_ready = 1. Accept when in_valid & ~cancel. Latch op, signedness and operand signs. For signed ops, latch absolute values of src1 and src2; for unsigned ops, latch them raw. Go to CALC, counter = 0.
  - CALC: one restoring step per cycle via div_iter_core. The counter increments each cycle. After the step with counter = 31 (32 cycles), go to DONE.
  - DONE: out_valid = 1 and out_result is stable. On out_ready, go to IDLE the next cycle.
- Latency: accept at cycle T, out_valid first high at T+33. Back-to-back issue is possible at T+34 at the earliest.
- in_valid with no op bit set: ignored, not accepted. More than one op bit set: undefined, and the bench must not drive it.
- Sign fixup, applied in the transition to DONE and registered:
  - Signed quotient is negated when dividend and divisor signs differ.
  - Signed remainder takes the dividend's sign.
- Divide by zero, regardless of signedness: quotient = 0xFFFFFFFF, remainder = dividend. No sign fixup is applied to the quotient.
- Overflow 0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000, remainder = 0.
- cancel:
  - In any state, the next state is IDLE, out_valid drops to 0 and the op is discarded.
  - cancel together with in_valid in IDLE: not accepted.
  - cancel together with out_ready in DONE: treated as cancel, and the result is not consumed.
- in_src and in_op may change after acceptance without effect.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- With the macro defined, IDLE detects these cases at accept and goes straight to DONE, so out_valid is high at T+1:
  - divisor == 0;
  - |dividend| < |divisor| (using unsigned magnitudes): quotient = 0, remainder = dividend;
  - divisor magnitude == 1: quotient = ±dividend, remainder = 0.
- Without the macro: every op takes the fixed 33-cycle path; results are identical in both builds.

Decomposition:
- Shared package holds:
  - op one-hot bit indices DIV_OP_DIV = 0, DIV_OP_DIVU = 1, DIV_OP_MOD = 2, DIV_OP_MODU = 3;
  - state encodings IDLE / CALC / DONE;
  - constant DIV_ITERS = 32.
- One sub-module, div_iter_core, is purely combinational:
  - inputs: partial remainder and quotient registers;
  - output: one shift-subtract-restore step.
- div_seq_ctrl owns all registers, the counter, the handshake and the fixups.

Test Plan:
- div.w: src1 = 0xFFFFFFF9 (-7), src2 = 2 -> out_result = 0xFFFFFFFD (-3); out_valid first high exactly 33 cycles after accept.
- mod.w: -7 % 2 -> 0xFFFFFFFF; modu 0xFFFFFFF9 % 2 -> 1; divu 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Divide by zero: div.w 5 / 0 -> 0xFFFFFFFF; mod.w 5 % 0 -> 5.
- Overflow: div.w 0x80000000 / 0xFFFFFFFF -> 0x80000000; mod.w same operands -> 0.
- cancel at cycle 10 of CALC:
  - out_valid never rises and in_ready = 1 next cycle;
  - a new op 100 / 7 (div.w) then returns 14 in 33 cycles.
- Backpressure:
  - out_ready held low 5 cycles in DONE -> out_result stable and in_ready = 0 throughout;
  - out_ready pulse -> IDLE the next cycle.
- With DIV_EARLY_OUT_EN: divu 3 / 10 -> 0 at T+1; without the macro -> 0 at T+33.
